add_tree_pipe: RTL

- Parametrised, pipelined multi-operand adder tree: sums NUM_IN unsigned WIDTH-bit operands plus a carry-in.
- One tree level per register stage, with valid/ready flow control on input and output.
- Successor to the fixed two-operand 8-bit pipelined adders and their combining adder: one block replaces the whole cluster, gains backpressure, and runs on a single clock domain.

---
 rtl/add_tree_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/add_tree_pipe.sv
// Pipelined multi-operand adder tree with valid/ready flow control, one tree level per stage.
// Optional accumulate-until-last mode is enabled by defining ADD_TREE_PIPE_ACCUM_EN.
module add_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int NUM_IN = 4,
`ifdef ADD_TREE_PIPE_ACCUM_EN
  parameter int ACC_EXTRA = 8,
`endif
  localparam int LEVELS = $clog2(NUM_IN),
  localparam int OUT_W = WIDTH + LEVELS,
`ifdef ADD_TREE_PIPE_ACCUM_EN
  localparam int SUM_W = OUT_W + ACC_EXTRA
`else
  localparam int SUM_W = OUT_W
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cin,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
`ifdef ADD_TREE_PIPE_ACCUM_EN
  input  logic                    in_last,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_W-1:0]        sum
);

  logic [LEVELS-1:0] stage_valid;
  logic [LEVELS:0]   ready;
  logic              down_ready;

  // Ready ripples back from the output; a stage is ready when empty or draining.
  always_comb begin
    ready = '0;
    ready[LEVELS] = down_ready;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      ready[k] = !stage_valid[k] || ready[k+1];
    end
  end

  assign in_ready = ready[0];

  genvar gi;
  for (gi = 0; gi < LEVELS; gi++) begin : g_stage
    localparam int LANES = NUM_IN >> (gi + 1);
    localparam int LW = WIDTH + gi + 1;

    logic [LANES*LW-1:0] data_reg;
    logic [LANES*LW-1:0] data_next;
    logic                valid_reg;
    logic                src_valid;
`ifdef ADD_TREE_PIPE_ACCUM_EN
    logic                last_reg;
    logic                src_last;
`endif

    if (gi == 0) begin : g_first
      assign src_valid = in_valid;
`ifdef ADD_TREE_PIPE_ACCUM_EN
      assign src_last = in_last;
`endif
      for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
        localparam logic CIN_LANE = (gj == 0);
        assign data_next[gj*LW +: LW] = LW'(in_data[2*gj*WIDTH +: WIDTH])
                                      + LW'(in_data[(2*gj+1)*WIDTH +: WIDTH])
                                      + LW'(cin & CIN_LANE);
      end
    end else begin : g_inner
      localparam int PW = LW - 1;
      assign src_valid = stage_valid[gi-1];
`ifdef ADD_TREE_PIPE_ACCUM_EN
      assign src_last = g_stage[gi-1].last_reg;
`endif
      for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
        assign data_next[gj*LW +: LW] = LW'(g_stage[gi-1].data_reg[2*gj*PW +: PW])
                                      + LW'(g_stage[gi-1].data_reg[(2*gj+1)*PW +: PW]);
      end
    end

    // Data only moves with a real beat so idle cycles leave the registers untouched.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
`ifdef ADD_TREE_PIPE_ACCUM_EN
        last_reg  <= 1'b0;
`endif
      end else if (ready[gi]) begin
        valid_reg <= src_valid;
        if (src_valid) begin
          data_reg <= data_next;
`ifdef ADD_TREE_PIPE_ACCUM_EN
          last_reg <= src_last;
`endif
        end
      end
    end

    assign stage_valid[gi] = valid_reg;
  end

`ifdef ADD_TREE_PIPE_ACCUM_EN
  logic [SUM_W-1:0] acc_reg;
  logic             acc_valid_reg;
  logic [SUM_W-1:0] acc_base;

  // The last tree stage stalls while a finished total waits for the consumer.
  assign down_ready = !acc_valid_reg || out_ready;
  assign acc_base   = acc_valid_reg ? '0 : acc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg       <= '0;
      acc_valid_reg <= 1'b0;
    end else if (stage_valid[LEVELS-1] && down_ready) begin
      acc_reg       <= acc_base + SUM_W'(g_stage[LEVELS-1].data_reg);
      acc_valid_reg <= g_stage[LEVELS-1].last_reg;
    end else if (acc_valid_reg && out_ready) begin
      acc_reg       <= '0;
      acc_valid_reg <= 1'b0;
    end
  end

  assign out_valid = acc_valid_reg;
  assign sum       = acc_reg;
`else
  assign down_ready = out_ready;
  assign out_valid  = stage_valid[LEVELS-1];
  assign sum        = g_stage[LEVELS-1].data_reg;
`endif

endmodule
